// File: rtl/seq_div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Holds the FSM state encoding and the divide-by-zero quotient pattern.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MAX_W = 64;

  // All ones of width w, right-aligned in a MAX_W-bit vector.
  function automatic logic [MAX_W-1:0] dbz_quotient(input int w);
    return {MAX_W{1'b1}} >> (MAX_W - w);
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract.
// Zero latency; no handshake, driven every cycle by the owning FSM.
module seq_div_step
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);

  logic [WIDTH+1:0] w_trial;
  logic [WIDTH:0]   w_shift;

  assign w_shift = {i_rem[WIDTH-1:0], i_bit};
  // Extra top bit turns the trial difference's sign into a borrow flag.
  assign w_trial = {i_rem, i_bit} - {2'b00, i_dvs};
  assign o_qbit  = ~w_trial[WIDTH+1];
  assign o_rem   = o_qbit ? w_trial[WIDTH:0] : w_shift;

endmodule

// File: rtl/seq_div_rem.sv
// Restoring divider, one radix-2 step per clock; result WIDTH+1 cycles after accept (1 for /0), held until i_out_ready.
// Define SEQ_DIV_REM_SIGNED_EN for two's-complement operands (magnitudes in the core, signs applied entering DONE).
module seq_div_rem
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start_valid,
  output logic             o_start_ready,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]      CNT_INIT = CW'(WIDTH - 1);
  localparam logic [MAX_W-1:0]   DBZ_FULL = dbz_quotient(WIDTH);
  localparam logic [WIDTH-1:0]   DBZ_Q    = DBZ_FULL[WIDTH-1:0];

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic             r_start_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic [WIDTH:0]   w_rem_nxt;
  logic             w_qbit;
  logic [WIDTH-1:0] w_q_raw;
  logic [WIDTH-1:0] w_r_raw;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH-1:0] w_q_fin;
  logic [WIDTH-1:0] w_r_fin;

  seq_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem  (r_rem),
    .i_bit  (r_dvd[WIDTH-1]),
    .i_dvs  (r_dvs),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

  // r_dvd doubles as the quotient shift register as dividend bits leave the top.
  assign w_q_raw = {r_dvd[WIDTH-2:0], w_qbit};
  assign w_r_raw = w_rem_nxt[WIDTH-1:0];

`ifdef SEQ_DIV_REM_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;

  assign w_dvd_mag = i_dividend[WIDTH-1] ? -i_dividend : i_dividend;
  assign w_dvs_mag = i_divisor[WIDTH-1]  ? -i_divisor  : i_divisor;
  assign w_q_fin   = r_neg_q ? -w_q_raw : w_q_raw;
  assign w_r_fin   = r_neg_r ? -w_r_raw : w_r_raw;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state == IDLE && i_start_valid) begin
      r_neg_q <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
      r_neg_r <= i_dividend[WIDTH-1];
    end
  end
`else
  assign w_dvd_mag = i_dividend;
  assign w_dvs_mag = i_divisor;
  assign w_q_fin   = w_q_raw;
  assign w_r_fin   = w_r_raw;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_rem         <= '0;
      r_dvd         <= '0;
      r_dvs         <= '0;
      r_start_ready <= 1'b1;
      r_out_valid   <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start_valid) begin
            r_rem         <= '0;
            r_dvd         <= w_dvd_mag;
            r_dvs         <= w_dvs_mag;
            r_start_ready <= 1'b0;
            if (i_divisor == '0) begin
              r_state       <= DONE;
              r_out_valid   <= 1'b1;
              r_quotient    <= DBZ_Q;
              r_remainder   <= i_dividend;
              r_div_by_zero <= 1'b1;
            end else begin
              r_state <= BUSY;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          r_rem <= w_rem_nxt;
          r_dvd <= w_q_raw;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            r_state       <= DONE;
            r_out_valid   <= 1'b1;
            r_quotient    <= w_q_fin;
            r_remainder   <= w_r_fin;
            r_div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          if (i_out_ready) begin
            r_state       <= IDLE;
            r_out_valid   <= 1'b0;
            r_start_ready <= 1'b1;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_out_valid   <= 1'b0;
          r_start_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_start_ready = r_start_ready;
  assign o_out_valid   = r_out_valid;
  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_div_rem.sv
// Directed self-checking bench for seq_div_rem at WIDTH=8.
// Expected values are hand-computed; signed vectors run when SEQ_DIV_REM_SIGNED_EN is defined.
module tb_seq_div_rem;

  localparam int W = 8;

`ifdef SEQ_DIV_REM_SIGNED_EN
  localparam logic [W-1:0] Q200_7 = 8'hF8;
  localparam logic [W-1:0] R200_7 = 8'h00;
`else
  localparam logic [W-1:0] Q200_7 = 8'd28;
  localparam logic [W-1:0] R200_7 = 8'd4;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_div_rem #(.WIDTH(W)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start_valid (start_valid),
    .o_start_ready (start_ready),
    .i_dividend    (dividend),
    .i_divisor     (divisor),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_quotient    (quotient),
    .o_remainder   (remainder),
    .o_div_by_zero (div_by_zero)
  );

  // Present operands for one accept edge; returns just after that edge.
  task automatic do_accept(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    dividend    = a;
    divisor     = b;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
  endtask

  // Cycles from the accept edge to the first edge at which out_valid is seen high.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 40) begin
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (start_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 8'd0 ||
        remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b q=%0d r=%0d dbz=%b, need 1 0 0 0 0",
               start_ready, out_valid, quotient, remainder, div_by_zero);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat;
    out_ready = 1'b1;
    do_accept(8'd200, 8'd7);
    wait_valid(lat);
    checks++;
    if (lat !== 9) begin
      errors++;
      $display("FAIL basic_latency: got %0d need 9", lat);
    end
    checks++;
    if (quotient !== Q200_7 || remainder !== R200_7 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: q=%0d r=%0d dbz=%b need q=%0d r=%0d dbz=0",
               quotient, remainder, div_by_zero, Q200_7, R200_7);
    end
    @(negedge clk);
    checks++;
    if (start_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: rdy=%b vld=%b need 1 0", start_ready, out_valid);
    end
  endtask

  task automatic test_backpressure;
    int lat;
    out_ready = 1'b0;
    do_accept(8'd16, 8'd3);
    wait_valid(lat);
    checks++;
    if (lat !== 9 || quotient !== 8'd5 || remainder !== 8'd1) begin
      errors++;
      $display("FAIL bp_result: lat=%0d q=%0d r=%0d need 9 5 1", lat, quotient, remainder);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || quotient !== 8'd5 || remainder !== 8'd1 ||
          start_ready !== 1'b0 || div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: vld=%b q=%0d r=%0d rdy=%b dbz=%b need 1 5 1 0 0",
                 i, out_valid, quotient, remainder, start_ready, div_by_zero);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || start_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_transfer: vld=%b rdy=%b need 0 1", out_valid, start_ready);
    end
  endtask

  task automatic test_div_zero;
    int lat;
    out_ready = 1'b1;
    do_accept(8'd100, 8'd0);
    wait_valid(lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL dbz_latency: got %0d need 1", lat);
    end
    checks++;
    if (quotient !== 8'd255 || remainder !== 8'd100 || div_by_zero !== 1'b1) begin
      errors++;
      $display("FAIL dbz_result: q=%0d r=%0d dbz=%b need 255 100 1",
               quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    checks++;
    if (start_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL dbz_idle: rdy=%b vld=%b need 1 0", start_ready, out_valid);
    end
  endtask

  task automatic test_edges;
    logic [W-1:0] vec [3][4];
    int lat;
    vec[0] = '{8'd255, 8'd1,  8'd255, 8'd0};
    vec[1] = '{8'd5,   8'd9,  8'd0,   8'd5};
    vec[2] = '{8'd0,   8'd13, 8'd0,   8'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_accept(vec[i][0], vec[i][1]);
      wait_valid(lat);
      checks++;
      if (lat !== 9 || quotient !== vec[i][2] || remainder !== vec[i][3] ||
          div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL edge%0d %0d/%0d: lat=%0d q=%0d r=%0d dbz=%b need 9 %0d %0d 0",
                 i, vec[i][0], vec[i][1], lat, quotient, remainder, div_by_zero,
                 vec[i][2], vec[i][3]);
      end
      @(negedge clk);
    end
    do_accept(8'd200, 8'd7);
    dividend = 8'd3;
    divisor  = 8'd1;
    wait_valid(lat);
    checks++;
    if (lat !== 9 || quotient !== Q200_7 || remainder !== R200_7) begin
      errors++;
      $display("FAIL input_change: lat=%0d q=%0d r=%0d need 9 %0d %0d",
               lat, quotient, remainder, Q200_7, R200_7);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_busy;
    int lat;
    logic seen;
    out_ready = 1'b1;
    do_accept(8'd200, 8'd7);
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (start_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 8'd0 ||
        remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy_state: rdy=%b vld=%b q=%0d r=%0d dbz=%b need 1 0 0 0 0",
               start_ready, out_valid, quotient, remainder, div_by_zero);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy_discard: out_valid rose=%b need 0", seen);
    end
    do_accept(8'd9, 8'd2);
    wait_valid(lat);
    checks++;
    if (lat !== 9 || quotient !== 8'd4 || remainder !== 8'd1) begin
      errors++;
      $display("FAIL rst_busy_next: lat=%0d q=%0d r=%0d need 9 4 1", lat, quotient, remainder);
    end
    @(negedge clk);
  endtask

`ifdef SEQ_DIV_REM_SIGNED_EN
  task automatic test_signed;
    logic [W-1:0] vec [3][4];
    int lat;
    vec[0] = '{8'hF0, 8'h03, 8'hFB, 8'hFF};
    vec[1] = '{8'h10, 8'hFD, 8'hFB, 8'h01};
    vec[2] = '{8'h80, 8'hFF, 8'h80, 8'h00};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_accept(vec[i][0], vec[i][1]);
      wait_valid(lat);
      checks++;
      if (lat !== 9 || quotient !== vec[i][2] || remainder !== vec[i][3] ||
          div_by_zero !== 1'b0) begin
        errors++;
        $display("FAIL signed%0d %h/%h: lat=%0d q=%h r=%h dbz=%b need 9 %h %h 0",
                 i, vec[i][0], vec[i][1], lat, quotient, remainder, div_by_zero,
                 vec[i][2], vec[i][3]);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_div_zero();
    test_edges();
    test_reset_mid_busy();
`ifdef SEQ_DIV_REM_SIGNED_EN
    test_signed();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_div_rem.md
Name: seq_div_rem

Overview:
- Multi-cycle restoring divider producing quotient and remainder of two WIDTH-bit operands.
- Provides the synthesizable counterpart to combinational `/` and `%`, which are simulation-only in our code.
- One radix-2 step per clock, with valid/ready handshakes on both the operand side and the result side.
- Instantiated wherever datapath logic needs division without a large combinational array.

Parameters:
- WIDTH, 8, bit width of dividend, divisor, quotient and remainder (WIDTH >= 2).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start_valid  in  1  operands present.
- start_ready  out  1  divider idle and able to accept operands.
- dividend  in  WIDTH  numerator; sampled on the accept edge only.
- divisor  in  WIDTH  denominator; sampled on the accept edge only.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- quotient  out  WIDTH  dividend / divisor, truncated.
- remainder  out  WIDTH  dividend % divisor.
- div_by_zero  out  1  result produced with divisor == 0.

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset values: state IDLE, start_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
- State IDLE:
  - start_ready=1.
  - An accept occurs on a rising edge with start_valid&&start_ready.
  - On accept, latch operands and clear partial remainder.
  - divisor!=0 -> BUSY, counter=WIDTH-1.
  - divisor==0 -> DONE.
- State BUSY, one restoring step per cycle:
  - Shift {partial remainder, dividend} left 1.
  - Trial-subtract the divisor; if non-negative, keep the difference and set the quotient LSB to 1, else set it to 0.
  - Partial remainder register is WIDTH+1 bits to hold the trial subtraction.
  - Counter decrements each step; on the step with counter==0 -> DONE.
- State DONE:
  - out_valid=1; quotient, remainder and div_by_zero are stable and held unchanged while out_ready=0.
  - out_valid&&out_ready -> IDLE on that edge.
  - start_ready=0 throughout BUSY and DONE, so no new accept can occur in the same cycle as the result transfer.
- Latency:
  - Normal division: out_valid rises exactly WIDTH+1 cycles after the accept edge (WIDTH=8 -> 9).
  - Divide by zero: out_valid rises 1 cycle after the accept edge.
  - Peak throughput: one division per WIDTH+2 cycles.
- Divide by zero: quotient=all ones, remainder=dividend, div_by_zero=1.
- div_by_zero is 0 for every normal result.
- Input changes after the accept edge have no effect on the operation in flight.
- rst asserted in any state, including mid-BUSY or DONE with out_valid pending: the operation is discarded and all outputs return to reset values on the next edge.
- Boundaries:
  - dividend < divisor -> quotient 0, remainder=dividend.
  - divisor 1 -> quotient=dividend, remainder 0.
  - dividend 0 -> 0,0.

Optional Feature:
- Macro: SEQ_DIV_REM_SIGNED_EN.
- Defined:
  - Operands and results are two's-complement.
  - Operands are converted to magnitudes on accept; the unsigned core runs unchanged.
  - Signs are applied when entering DONE, so latency is identical to the unsigned build.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Most-negative / -1 wraps: quotient = most-negative value, remainder 0.
  - Divide by zero: quotient = all ones (-1), remainder=dividend.
- Undefined: pure unsigned operation as described above.

Decomposition:
- Shared package seq_div_pkg contains:
  - the state enum typedef (IDLE, BUSY, DONE);
  - a function returning the divide-by-zero quotient constant (all ones of WIDTH).
- One sub-module is natural: seq_div_step, a combinational single restoring step.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new partial remainder, quotient bit.
  - The FSM, counter and handshakes remain in seq_div_rem.

Test Plan:
- WIDTH=8, accept 200/7 with out_ready=1 -> out_valid 9 cycles after accept, quotient=28, remainder=4, div_by_zero=0; IDLE next cycle.
- Accept 16/3, hold out_ready=0 for 5 cycles after out_valid -> quotient=5, remainder=1 stable throughout, start_ready=0; single transfer when out_ready=1.
- Accept 100/0 -> out_valid 1 cycle after accept, quotient=255, remainder=100, div_by_zero=1.
- Edge values:
  - 255/1 -> 255, 0.
  - 5/9 -> 0, 5.
  - 0/13 -> 0, 0.
  - Change dividend/divisor inputs during BUSY -> results unaffected.
- Accept 200/7, assert rst for 1 cycle at cycle 4 of BUSY -> out_valid never rises for that operation, all outputs at reset values, start_ready=1 next cycle; a following 9/2 returns 4, 1.
- SEQ_DIV_REM_SIGNED_EN defined:
  - -16/3 -> 0xFB (-5), 0xFF (-1).
  - 16/-3 -> 0xFB, 0x01.
  - -128/-1 -> 0x80, 0x00.
  - Latency 9 cycles for all three.
